// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code parser: set-2 prefix bytes,
// pop-handshake FSM state encoding and the {ext, code} key identifier type.
package ps2_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Pop-handshake FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Key identity as stored in held_code: extended flag above the raw code
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  // True for bytes that only modify the following code byte
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_scancode_parser.sv
// PS/2 set-2 scan-code parser sitting behind the keyboard receiver FIFO.
// Pops one byte per IDLE/POP/GAP loop, strips E0/F0 prefixes, emits one-cycle
// key events, tracks the held key and counts make events (wrapping counter).
// Optional build macro: REPEAT_FILTER_EN suppresses typematic repeats of the
// currently held key (no event, no count).
module ps2_scancode_parser
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_ready,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_break,
  output logic             ev_ext,
  output logic             key_held,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow_seen
);

  logic [1:0]       r_state;
  logic [7:0]       r_byte;
  logic             r_nextdata_n;
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic             r_ev_valid;
  logic [7:0]       r_ev_code;
  logic             r_ev_break;
  logic             r_ev_ext;
  logic             r_key_held;
  key_t             r_held_code;
  logic [CNT_W-1:0] r_press_count;
  logic             r_overflow_seen;

  logic w_pop;
  logic w_code_byte;
  key_t w_key;
  logic w_match;
  logic w_repeat;
  logic w_emit;
  logic w_make;
  logic w_release;

  // Byte under processing is only meaningful during the POP cycle
  assign w_pop       = (r_state == ST_POP);
  assign w_code_byte = w_pop && !is_prefix(r_byte);
  assign w_key       = '{ext: r_ext_pend, code: r_byte};
  assign w_match     = r_key_held && (r_held_code == w_key);

`ifdef REPEAT_FILTER_EN
  // A make of the key already held is a typematic repeat and is dropped
  assign w_repeat = !r_brk_pend && w_match;
`else
  assign w_repeat = 1'b0;
`endif

  assign w_emit    = w_code_byte && !w_repeat;
  assign w_make    = w_emit && !r_brk_pend;
  assign w_release = w_emit && r_brk_pend && w_match;

  // Pop handshake: latch the head byte, strobe nextdata_n for one cycle,
  // then let the receiver's read pointer settle before looking again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_nextdata_n <= 1'b1;
          if (ps2_ready) begin
            r_byte       <= ps2_data;
            r_nextdata_n <= 1'b0;
            r_state      <= ST_POP;
          end
        end
        ST_POP: begin
          r_nextdata_n <= 1'b1;
          r_state      <= ST_GAP;
        end
        ST_GAP: begin
          r_nextdata_n <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_nextdata_n <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Prefix flags accumulate in any order and clear on the next code byte,
  // whether or not that byte produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_pop) begin
      if (r_byte == SC_EXT) begin
        r_ext_pend <= 1'b1;
      end else if (r_byte == SC_BRK) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  // Event outputs: valid pulses for one cycle, payload holds until the next event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      r_ev_code  <= 8'h00;
      r_ev_break <= 1'b0;
      r_ev_ext   <= 1'b0;
    end else begin
      r_ev_valid <= w_emit;
      if (w_emit) begin
        r_ev_code  <= r_byte;
        r_ev_break <= r_brk_pend;
        r_ev_ext   <= r_ext_pend;
      end
    end
  end

  // Held-key tracker and make counter; a break only releases the matching key
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_held    <= 1'b0;
      r_held_code   <= '0;
      r_press_count <= '0;
    end else if (w_make) begin
      r_key_held    <= 1'b1;
      r_held_code   <= w_key;
      r_press_count <= r_press_count + CNT_W'(1);
    end else if (w_release) begin
      r_key_held <= 1'b0;
    end
  end

  // Sticky receiver overflow indication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow_seen <= 1'b0;
    end else if (ps2_overflow) begin
      r_overflow_seen <= 1'b1;
    end
  end

  assign nextdata_n    = r_nextdata_n;
  assign ev_valid      = r_ev_valid;
  assign ev_code       = r_ev_code;
  assign ev_break      = r_ev_break;
  assign ev_ext        = r_ev_ext;
  assign key_held      = r_key_held;
  assign held_code     = r_held_code;
  assign press_count   = r_press_count;
  assign overflow_seen = r_overflow_seen;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Scoreboard bench for ps2_scancode_parser: a queue models the receiver FIFO,
// a reference parser predicts events as bytes are pushed, and a monitor pops
// and compares predictions whenever the DUT pulses ev_valid.
module tb_ps2_scancode_parser;

  localparam int unsigned CntW = 8;

  logic            clk;
  logic            rst;
  logic            ps2_ready;
  logic [7:0]      ps2_data;
  logic            ps2_overflow;
  logic            nextdata_n;
  logic            ev_valid;
  logic [7:0]      ev_code;
  logic            ev_break;
  logic            ev_ext;
  logic            key_held;
  logic [8:0]      held_code;
  logic [CntW-1:0] press_count;
  logic            overflow_seen;

  ps2_scancode_parser #(
    .CNT_W (CntW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_ready     (ps2_ready),
    .ps2_data      (ps2_data),
    .ps2_overflow  (ps2_overflow),
    .nextdata_n    (nextdata_n),
    .ev_valid      (ev_valid),
    .ev_code       (ev_code),
    .ev_break      (ev_break),
    .ev_ext        (ev_ext),
    .key_held      (key_held),
    .held_code     (held_code),
    .press_count   (press_count),
    .overflow_seen (overflow_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      code;
    logic            brk;
    logic            ext;
    logic            held;
    logic [8:0]      hcode;
    logic [CntW-1:0] cnt;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];

  // Reference parser state
  logic            m_ext  = 1'b0;
  logic            m_brk  = 1'b0;
  logic            m_held = 1'b0;
  logic [8:0]      m_code = '0;
  logic [CntW-1:0] m_cnt  = '0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic update_if();
    ps2_ready = (fifo_q.size() != 0);
    ps2_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic model_reset();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_held = 1'b0;
    m_code = '0;
    m_cnt  = '0;
  endtask

  // Predict the effect of one byte and queue the expected event, if any
  task automatic model_byte(input logic [7:0] b);
    logic [8:0] key;
    logic       emit;
    exp_t       e;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      key  = {m_ext, b};
      emit = 1'b1;
      if (m_brk) begin
        if (m_held && m_code == key) m_held = 1'b0;
      end else begin
`ifdef REPEAT_FILTER_EN
        if (m_held && m_code == key) emit = 1'b0;
`endif
        if (emit) begin
          m_held = 1'b1;
          m_code = key;
          m_cnt  = m_cnt + 1'b1;
        end
      end
      if (emit) begin
        e = '{code: b, brk: m_brk, ext: m_ext, held: m_held, hcode: m_code, cnt: m_cnt};
        exp_q.push_back(e);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
    update_if();
  endtask

  // Wait until the FIFO is empty and the DUT has been quiet for a few cycles
  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && nextdata_n) quiet++;
      else quiet = 0;
      if (quiet >= 4) return;
    end
    check_val("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Receiver side: a low strobe seen mid-cycle pops the head byte
  logic prev_nd = 1'b1;
  always @(negedge clk) begin
    if (!nextdata_n) begin
      check_val("nd_single", {31'd0, prev_nd}, 32'd1);
      check_val("pop_nonempty", {31'd0, (fifo_q.size() != 0)}, 32'd1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      update_if();
    end
    prev_nd = nextdata_n;
  end

  // Event monitor / scoreboard compare
  logic prev_ev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ev_valid) begin
      check_val("ev_pulse", {31'd0, prev_ev}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("ev_unexpected", {24'd0, ev_code}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("ev_code", {24'd0, ev_code}, {24'd0, e.code});
        check_val("ev_break", {31'd0, ev_break}, {31'd0, e.brk});
        check_val("ev_ext", {31'd0, ev_ext}, {31'd0, e.ext});
        check_val("ev_key_held", {31'd0, key_held}, {31'd0, e.held});
        check_val("ev_held_code", {23'd0, held_code}, {23'd0, e.hcode});
        check_val("ev_count", {24'd0, press_count}, {24'd0, e.cnt});
      end
    end
    prev_ev = ev_valid;
  end

  initial begin
    rst          = 1'b1;
    ps2_overflow = 1'b0;
    ps2_ready    = 1'b0;
    ps2_data     = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_nd", {31'd0, nextdata_n}, 32'd1);
    check_val("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check_val("rst_ev_code", {24'd0, ev_code}, 32'd0);
    check_val("rst_ev_brk_ext", {30'd0, ev_break, ev_ext}, 32'd0);
    check_val("rst_key_held", {31'd0, key_held}, 32'd0);
    check_val("rst_held_code", {23'd0, held_code}, 32'd0);
    check_val("rst_count", {24'd0, press_count}, 32'd0);
    check_val("rst_ovf", {31'd0, overflow_seen}, 32'd0);
    rst = 1'b0;

    // Single make
    @(negedge clk);
    push_byte(8'h1C);
    drain();
    check_val("make_count", {24'd0, press_count}, 32'd1);
    check_val("make_held_code", {23'd0, held_code}, 32'h01C);

    // Matching break
    push_byte(8'hF0);
    push_byte(8'h1C);
    drain();
    check_val("brk_key_held", {31'd0, key_held}, 32'd0);
    check_val("brk_count", {24'd0, press_count}, 32'd1);

    // Extended make and break
    push_byte(8'hE0);
    push_byte(8'h75);
    push_byte(8'hE0);
    push_byte(8'hF0);
    push_byte(8'h75);
    drain();
    check_val("ext_key_held", {31'd0, key_held}, 32'd0);
    check_val("ext_held_code", {23'd0, held_code}, 32'h175);
    check_val("ext_count", {24'd0, press_count}, 32'd2);

    // Typematic repeats
    push_byte(8'h1C);
    push_byte(8'h1C);
    push_byte(8'h1C);
    drain();
`ifdef REPEAT_FILTER_EN
    check_val("rep_count", {24'd0, press_count}, 32'd3);
`else
    check_val("rep_count", {24'd0, press_count}, 32'd5);
`endif
    // Non-matching break leaves the held key alone; reversed prefix order
    push_byte(8'hF0);
    push_byte(8'h2A);
    push_byte(8'hF0);
    push_byte(8'hE0);
    push_byte(8'h1C);
    drain();
    check_val("nonmatch_held", {31'd0, key_held}, 32'd1);
    push_byte(8'hF0);
    push_byte(8'h1C);
    // Odd code bytes are ordinary events
    push_byte(8'hE1);
    push_byte(8'h00);
    push_byte(8'hFF);
    drain();
    check_val("odd_held_code", {23'd0, held_code}, 32'h0FF);

    // Sticky overflow
    @(negedge clk);
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    repeat (5) @(negedge clk);
    check_val("ovf_sticky", {31'd0, overflow_seen}, 32'd1);

    // Counter wrap after 256 make/break pairs
    do_reset();
    check_val("ovf_cleared", {31'd0, overflow_seen}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      push_byte(8'h1C);
      push_byte(8'hF0);
      push_byte(8'h1C);
      drain();
    end
    check_val("wrap_count", {24'd0, press_count}, 32'd0);

    // Reset during POP of an F0 loses the break prefix
    @(negedge clk);
    push_byte(8'hF0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (!nextdata_n) seen = 1'b1;
      end
      check_val("pop_seen", {31'd0, seen}, 32'd1);
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_val("rst_pop_nd", {31'd0, nextdata_n}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    push_byte(8'h1C);
    drain();
    check_val("post_rst_break", {31'd0, ev_break}, 32'd0);
    check_val("post_rst_count", {24'd0, press_count}, 32'd1);

    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
